// File: rtl/subneg_mem_arbiter_if.sv
// subneg_mem_arbiter_if: CPU/host request ports and shared external SRAM bus of subneg_mem_arbiter
interface subneg_mem_arbiter_if;
  logic       cpu_req, cpu_we, cpu_done;
  logic [7:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic       host_req, host_we, host_done;
  logic [7:0] host_addr, host_wdata, host_rdata;
  logic [7:0] bus_in, bus_out;
  logic       bus_oe, mem_latch_clk, mem_oe_n, mem_we_n, out_latch_clk, busy, owner;
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, host_req, host_we, host_addr, host_wdata, bus_in,
    output cpu_done, cpu_rdata, host_done, host_rdata, bus_out, bus_oe, mem_latch_clk,
           mem_oe_n, mem_we_n, out_latch_clk, busy, owner
  );
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, host_req, host_we, host_addr, host_wdata, bus_in,
    input  cpu_done, cpu_rdata, host_done, host_rdata, bus_out, bus_oe, mem_latch_clk,
           mem_oe_n, mem_we_n, out_latch_clk, busy, owner
  );
endinterface

// File: rtl/subneg_mem_arbiter.sv
// subneg_mem_arbiter: CPU/host SRAM bus sequencer; SUBNEG_ARB_RR_EN selects round-robin ties, else host wins ties
module subneg_mem_arbiter (
  input logic clk,
  input logic rst_n,
  subneg_mem_arbiter_if.slave arb
);
  typedef enum logic [3:0] {IDLE, ADDR, LATCH, RD_OE, RD_SAMPLE, RD_DONE, WR_DATA, WR_STROBE, WR_END} state_t;
  state_t state, state_d;
  logic [7:0] addr_q, addr_d, wdata_q, wdata_d;
  logic we_q, we_d, owner_d, last_owner, grant_host, fin_d, wr_d;
`ifdef SUBNEG_ARB_RR_EN
  assign grant_host = arb.host_req & (~arb.cpu_req | ~last_owner);
`else
  assign grant_host = arb.host_req | (arb.host_req & last_owner);
`endif
  assign fin_d = state_d inside {RD_DONE, WR_END};
  assign wr_d = state_d inside {WR_DATA, WR_STROBE, WR_END};
  always_comb begin
    state_d = state;
    addr_d = addr_q;
    wdata_d = wdata_q;
    we_d = we_q;
    owner_d = arb.owner;
    case (state)
      IDLE: if (arb.cpu_req || arb.host_req) begin
        state_d = ADDR;
        owner_d = grant_host;
        addr_d = grant_host ? arb.host_addr : arb.cpu_addr;
        wdata_d = grant_host ? arb.host_wdata : arb.cpu_wdata;
        we_d = grant_host ? arb.host_we : arb.cpu_we;
      end
      ADDR: state_d = LATCH;
      LATCH: state_d = we_q ? WR_DATA : RD_OE;
      RD_OE: state_d = RD_SAMPLE;
      RD_SAMPLE: state_d = RD_DONE;
      WR_DATA: state_d = WR_STROBE;
      WR_STROBE: state_d = WR_END;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      addr_q <= 8'h00;
      wdata_q <= 8'h00;
      we_q <= 1'b0;
      last_owner <= 1'b1;
      arb.bus_out <= 8'h00;
      arb.bus_oe <= 1'b0;
      arb.mem_latch_clk <= 1'b0;
      arb.mem_oe_n <= 1'b1;
      arb.mem_we_n <= 1'b1;
      arb.out_latch_clk <= 1'b0;
      arb.cpu_done <= 1'b0;
      arb.host_done <= 1'b0;
      arb.cpu_rdata <= 8'h00;
      arb.host_rdata <= 8'h00;
      arb.busy <= 1'b0;
      arb.owner <= 1'b0;
    end else begin
      state <= state_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      we_q <= we_d;
      arb.bus_out <= state_d == IDLE ? 8'h00 : wr_d ? wdata_d : addr_d;
      arb.bus_oe <= state_d inside {ADDR, LATCH, WR_DATA, WR_STROBE, WR_END};
      arb.mem_latch_clk <= state_d inside {LATCH, RD_OE, RD_SAMPLE, WR_DATA, WR_STROBE};
      arb.mem_oe_n <= !(state_d inside {RD_OE, RD_SAMPLE});
      arb.mem_we_n <= !(state_d == WR_STROBE && addr_d != 8'hFF);
      arb.out_latch_clk <= state_d == WR_STROBE && addr_d == 8'hFF;
      arb.cpu_done <= fin_d && !owner_d;
      arb.host_done <= fin_d && owner_d;
      arb.busy <= state_d != IDLE;
      arb.owner <= owner_d;
      if (state == RD_SAMPLE && !arb.owner) arb.cpu_rdata <= arb.bus_in;
      if (state == RD_SAMPLE && arb.owner) arb.host_rdata <= arb.bus_in;
      if (state == RD_DONE || state == WR_END) last_owner <= arb.owner;
    end
  end
endmodule

// File: tb/tb_subneg_mem_arbiter.sv
// tb_subneg_mem_arbiter: directed bench with SRAM, address latch and output latch models
module tb_subneg_mem_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0, bad = 0, conflicts = 0, ol_cnt = 0;
  logic [7:0] mem [256];
  logic [7:0] lat, out_reg;
  logic [7:0] c_bus [1:32], c_crd [1:32], c_hrd [1:32];
  logic c_oe [1:32], c_lc [1:32], c_moe [1:32], c_we [1:32], c_ol [1:32];
  logic c_cd [1:32], c_hd [1:32], c_busy [1:32], c_own [1:32];
`ifdef SUBNEG_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  subneg_mem_arbiter_if arb_if ();
  subneg_mem_arbiter dut (.clk(clk), .rst_n(rst_n), .arb(arb_if));
  always #5 clk = ~clk;
  assign arb_if.bus_in = arb_if.mem_oe_n ? 8'h00 : mem[lat];
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h10] = 8'h5A;
    mem[8'h40] = 8'hA1;
    mem[8'h41] = 8'hB2;
    mem[8'hFF] = 8'h99;
    forever begin
      @(negedge arb_if.mem_we_n);
      @(posedge arb_if.mem_we_n);
      mem[lat] = arb_if.bus_out;
    end
  end
  initial forever begin
    @(posedge arb_if.mem_latch_clk);
    lat = arb_if.bus_out;
  end
  initial forever begin
    @(posedge arb_if.out_latch_clk);
    out_reg = arb_if.bus_out;
    ol_cnt++;
  end
  always @(negedge clk) if (arb_if.bus_oe === 1'b1 && arb_if.mem_oe_n === 1'b0) conflicts++;

  task automatic clear_inputs();
    arb_if.cpu_req = 0; arb_if.cpu_we = 0; arb_if.cpu_addr = 0; arb_if.cpu_wdata = 0;
    arb_if.host_req = 0; arb_if.host_we = 0; arb_if.host_addr = 0; arb_if.host_wdata = 0;
  endtask

  task automatic start(input bit h, input bit we, input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    if (h) begin
      arb_if.host_we = we; arb_if.host_addr = a; arb_if.host_wdata = d; arb_if.host_req = 1;
    end else begin
      arb_if.cpu_we = we; arb_if.cpu_addr = a; arb_if.cpu_wdata = d; arb_if.cpu_req = 1;
    end
  endtask

  task automatic capture(input int n, input bit drop, input bit scramble);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      c_bus[k] = arb_if.bus_out; c_oe[k] = arb_if.bus_oe; c_lc[k] = arb_if.mem_latch_clk;
      c_moe[k] = arb_if.mem_oe_n; c_we[k] = arb_if.mem_we_n; c_ol[k] = arb_if.out_latch_clk;
      c_cd[k] = arb_if.cpu_done; c_hd[k] = arb_if.host_done; c_busy[k] = arb_if.busy;
      c_own[k] = arb_if.owner; c_crd[k] = arb_if.cpu_rdata; c_hrd[k] = arb_if.host_rdata;
      if (scramble && k == 1) begin
        arb_if.host_addr = 8'h21; arb_if.host_wdata = 8'hEE;
        arb_if.cpu_addr = 8'h11; arb_if.cpu_wdata = 8'hEE;
      end
      if (drop && arb_if.cpu_done) arb_if.cpu_req = 0;
      if (drop && arb_if.host_done) arb_if.host_req = 0;
    end
  endtask

  task automatic do_reset();
    rst_n = 0;
    clear_inputs();
    repeat (3) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    logic [32:0] obs;
    rst_n = 0;
    clear_inputs();
    @(negedge clk);
    obs = {arb_if.bus_out, arb_if.bus_oe, arb_if.mem_latch_clk, arb_if.mem_oe_n, arb_if.mem_we_n,
           arb_if.out_latch_clk, arb_if.cpu_done, arb_if.host_done, arb_if.cpu_rdata,
           arb_if.host_rdata, arb_if.busy, arb_if.owner};
    total++;
    if (obs !== {8'h00, 7'b0011000, 8'h00, 8'h00, 2'b00}) begin
      bad++; $display("FAIL reset_held: got %h want %h", obs, {8'h00, 7'b0011000, 8'h00, 8'h00, 2'b00});
    end
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (2) @(negedge clk);
    obs = {arb_if.bus_out, arb_if.bus_oe, arb_if.mem_latch_clk, arb_if.mem_oe_n, arb_if.mem_we_n,
           arb_if.out_latch_clk, arb_if.cpu_done, arb_if.host_done, arb_if.cpu_rdata,
           arb_if.host_rdata, arb_if.busy, arb_if.owner};
    total++;
    if (obs !== {8'h00, 7'b0011000, 8'h00, 8'h00, 2'b00}) begin
      bad++; $display("FAIL reset_idle: got %h want %h", obs, {8'h00, 7'b0011000, 8'h00, 8'h00, 2'b00});
    end
  endtask

  task automatic test_cpu_read();
    logic [6:0] cd, hd, bz;
    start(0, 0, 8'h10, 8'h00);
    capture(7, 1, 0);
    for (int k = 1; k <= 7; k++) begin
      cd = {cd[5:0], c_cd[k]}; hd = {hd[5:0], c_hd[k]}; bz = {bz[5:0], c_busy[k]};
    end
    total++;
    if ({c_oe[1], c_bus[1], c_lc[1], c_moe[1]} !== {1'b1, 8'h10, 1'b0, 1'b1}) begin
      bad++; $display("FAIL rd_addr: got %h want %h", {c_oe[1], c_bus[1], c_lc[1], c_moe[1]}, {1'b1, 8'h10, 1'b0, 1'b1});
    end
    total++;
    if ({c_lc[2], c_oe[2], c_bus[2], c_moe[2]} !== {1'b1, 1'b1, 8'h10, 1'b1}) begin
      bad++; $display("FAIL rd_latch: got %h want %h", {c_lc[2], c_oe[2], c_bus[2], c_moe[2]}, {1'b1, 1'b1, 8'h10, 1'b1});
    end
    total++;
    if ({c_oe[3], c_moe[3], c_oe[4], c_moe[4]} !== 4'b0000) begin
      bad++; $display("FAIL rd_oe: got %b want 0000", {c_oe[3], c_moe[3], c_oe[4], c_moe[4]});
    end
    total++;
    if ({c_cd[5], c_crd[5], c_moe[5], c_lc[5]} !== {1'b1, 8'h5A, 1'b1, 1'b0}) begin
      bad++; $display("FAIL rd_done: got %h want %h", {c_cd[5], c_crd[5], c_moe[5], c_lc[5]}, {1'b1, 8'h5A, 1'b1, 1'b0});
    end
    total++;
    if ({cd, hd, bz} !== {7'b0000100, 7'b0000000, 7'b1111100}) begin
      bad++; $display("FAIL rd_timing: got %b want %b", {cd, hd, bz}, {7'b0000100, 7'b0000000, 7'b1111100});
    end
  endtask

  task automatic test_host_write();
    logic [6:0] we, cd, hd;
    start(1, 1, 8'h20, 8'h33);
    capture(7, 1, 1);
    for (int k = 1; k <= 7; k++) begin
      we = {we[5:0], c_we[k]}; cd = {cd[5:0], c_cd[k]}; hd = {hd[5:0], c_hd[k]};
    end
    total++;
    if ({c_own[1], c_oe[1], c_bus[1]} !== {1'b1, 1'b1, 8'h20}) begin
      bad++; $display("FAIL wr_addr: got %h want %h", {c_own[1], c_oe[1], c_bus[1]}, {1'b1, 1'b1, 8'h20});
    end
    total++;
    if ({lat, c_bus[2], c_lc[2]} !== {8'h20, 8'h20, 1'b1}) begin
      bad++; $display("FAIL wr_latch: got %h want %h", {lat, c_bus[2], c_lc[2]}, {8'h20, 8'h20, 1'b1});
    end
    total++;
    if ({c_bus[3], c_oe[3], c_lc[3]} !== {8'h33, 1'b1, 1'b1}) begin
      bad++; $display("FAIL wr_data: got %h want %h", {c_bus[3], c_oe[3], c_lc[3]}, {8'h33, 1'b1, 1'b1});
    end
    total++;
    if (we !== 7'b1110111) begin
      bad++; $display("FAIL wr_strobe: got %b want 1110111", we);
    end
    total++;
    if ({c_bus[4], c_bus[5], c_oe[5]} !== {8'h33, 8'h33, 1'b1}) begin
      bad++; $display("FAIL wr_hold: got %h want %h", {c_bus[4], c_bus[5], c_oe[5]}, {8'h33, 8'h33, 1'b1});
    end
    total++;
    if (mem[8'h20] !== 8'h33 || mem[8'h21] !== 8'h00) begin
      bad++; $display("FAIL wr_sram: got %h/%h want 33/00", mem[8'h20], mem[8'h21]);
    end
    total++;
    if ({hd, cd} !== {7'b0000100, 7'b0000000}) begin
      bad++; $display("FAIL wr_done: got %b want %b", {hd, cd}, {7'b0000100, 7'b0000000});
    end
  endtask

  task automatic test_out_latch();
    logic [6:0] ol, we, cd;
    int n0;
    n0 = ol_cnt;
    start(0, 1, 8'hFF, 8'h77);
    capture(7, 1, 0);
    for (int k = 1; k <= 7; k++) begin
      ol = {ol[5:0], c_ol[k]}; we = {we[5:0], c_we[k]}; cd = {cd[5:0], c_cd[k]};
    end
    total++;
    if ({ol, we} !== {7'b0001000, 7'b1111111}) begin
      bad++; $display("FAIL ff_strobes: got %b want %b", {ol, we}, {7'b0001000, 7'b1111111});
    end
    total++;
    if (out_reg !== 8'h77 || ol_cnt - n0 !== 1) begin
      bad++; $display("FAIL ff_latch: got %h x%0d want 77 x1", out_reg, ol_cnt - n0);
    end
    total++;
    if (mem[8'hFF] !== 8'h99) begin
      bad++; $display("FAIL ff_sram: got %h want 99", mem[8'hFF]);
    end
    total++;
    if ({cd, c_bus[3], c_bus[5]} !== {7'b0000100, 8'h77, 8'h77}) begin
      bad++; $display("FAIL ff_done: got %h want %h", {cd, c_bus[3], c_bus[5]}, {7'b0000100, 8'h77, 8'h77});
    end
  endtask

  task automatic test_contention();
    logic [29:0] cd, hd, ecd, ehd;
    do_reset();
    @(negedge clk);
    arb_if.cpu_addr = 8'h10; arb_if.host_addr = 8'h40;
    arb_if.cpu_req = 1; arb_if.host_req = 1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      cd = {cd[28:0], arb_if.cpu_done}; hd = {hd[28:0], arb_if.host_done};
      ecd = {ecd[28:0], (k == 29) || (RR && (k == 5 || k == 17))};
      ehd = {ehd[28:0], RR ? (k == 11 || k == 23) : (k <= 23 && k % 6 == 5)};
      c_crd[k] = arb_if.cpu_rdata; c_hrd[k] = arb_if.host_rdata;
      if (k == 24) arb_if.host_req = 0;
      if (k == 29) arb_if.cpu_req = 0;
    end
    total++;
    if (cd !== ecd) begin
      bad++; $display("FAIL tie_cpu_done: got %b want %b", cd, ecd);
    end
    total++;
    if (hd !== ehd) begin
      bad++; $display("FAIL tie_host_done: got %b want %b", hd, ehd);
    end
    total++;
    if ({c_hrd[23], c_crd[29]} !== {8'hA1, 8'h5A}) begin
      bad++; $display("FAIL tie_rdata: got %h want %h", {c_hrd[23], c_crd[29]}, {8'hA1, 8'h5A});
    end
  endtask

  task automatic test_reset_mid_write();
    int n;
    start(0, 1, 8'h30, 8'h42);
    repeat (4) @(negedge clk);
    total++;
    if (arb_if.mem_we_n !== 1'b0) begin
      bad++; $display("FAIL abort_strobe: got %b want 0", arb_if.mem_we_n);
    end
    rst_n = 0;
    #1;
    total++;
    if ({arb_if.mem_we_n, arb_if.bus_oe, arb_if.busy} !== 3'b100) begin
      bad++; $display("FAIL abort_async: got %b want 100", {arb_if.mem_we_n, arb_if.bus_oe, arb_if.busy});
    end
    arb_if.cpu_req = 0;
    n = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 1) rst_n = 1;
      if (arb_if.cpu_done || arb_if.host_done || arb_if.busy) n++;
    end
    total++;
    if (n !== 0) begin
      bad++; $display("FAIL abort_quiet: got %0d active cycles want 0", n);
    end
    start(0, 0, 8'h10, 8'h00);
    capture(7, 1, 0);
    total++;
    if ({c_crd[4], c_crd[5], c_cd[5], c_cd[6]} !== {8'h00, 8'h5A, 1'b1, 1'b0}) begin
      bad++; $display("FAIL abort_recover: got %h want %h", {c_crd[4], c_crd[5], c_cd[5], c_cd[6]}, {8'h00, 8'h5A, 1'b1, 1'b0});
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] cd;
    start(0, 0, 8'h40, 8'h00);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      cd = {cd[10:0], arb_if.cpu_done};
      c_crd[k] = arb_if.cpu_rdata; c_bus[k] = arb_if.bus_out;
      c_oe[k] = arb_if.bus_oe; c_busy[k] = arb_if.busy;
      if (k == 5) arb_if.cpu_addr = 8'h41;
      if (k == 11) arb_if.cpu_req = 0;
    end
    total++;
    if (cd !== 12'b000010000010) begin
      bad++; $display("FAIL b2b_done: got %b want 000010000010", cd);
    end
    total++;
    if ({c_crd[5], c_crd[10], c_crd[11]} !== {8'hA1, 8'hA1, 8'hB2}) begin
      bad++; $display("FAIL b2b_rdata: got %h want %h", {c_crd[5], c_crd[10], c_crd[11]}, {8'hA1, 8'hA1, 8'hB2});
    end
    total++;
    if ({c_busy[6], c_oe[7], c_bus[7]} !== {1'b0, 1'b1, 8'h41}) begin
      bad++; $display("FAIL b2b_restart: got %h want %h", {c_busy[6], c_oe[7], c_bus[7]}, {1'b0, 1'b1, 8'h41});
    end
  endtask

  task automatic test_bus_safety();
    total++;
    if (conflicts !== 0) begin
      bad++; $display("FAIL oe_overlap: got %0d cycles want 0", conflicts);
    end
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_host_write();
    test_out_latch();
    test_contention();
    test_reset_mid_write();
    test_back_to_back();
    test_bus_safety();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/subneg_mem_arbiter.md
# subneg_mem_arbiter

Bus-cycle sequencer and two-port arbiter for the shared external 8-bit SRAM bus of the SUBNEG core, using the address latch, SRAM OE/WE and output latch. Two requesters share one physical bus: the CPU core (fetch/operand/write-back accesses) and a host loader port (program download and inspection). The block turns single-word read/write requests into a fixed multi-cycle strobe sequence. It also maps writes to address 0xFF onto the output latch instead of SRAM.

## Interface
Parameters: none.

Ports (name, direction, width, meaning):
- `clk` in 1: system clock.
- `rst_n` in 1: one clock; reset is asynchronous and active-low.
- `cpu_req` in 1: CPU access request; held with operands until `cpu_done`.
- `cpu_we` in 1: 1 = write, 0 = read.
- `cpu_addr` in 8: word address.
- `cpu_wdata` in 8: write data.
- `cpu_done` out 1: one-cycle completion pulse.
- `cpu_rdata` out 8: read data, valid while `cpu_done`=1, held until the next CPU read completes.
- `host_req`, `host_we`, `host_addr`, `host_wdata`, `host_done`, `host_rdata`: same as the CPU port, for the host loader.
- `bus_in` in 8: data bus input path.
- `bus_out` out 8: data bus output path.
- `bus_oe` out 1: 1 = block drives the bus.
- `mem_latch_clk` out 1: address latch clock; rising edge captures `bus_out`.
- `mem_oe_n` out 1: SRAM output enable, active low.
- `mem_we_n` out 1: SRAM write enable, active low.
- `out_latch_clk` out 1: output latch clock for address 0xFF writes.
- `busy` out 1: an access is in progress (state ≠ IDLE).
- `owner` out 1: 0 = CPU, 1 = host; valid while `busy`.

## Operation
- All outputs are registered Moore decodes of the state.
- Reset values:
  - `bus_out`=0, `bus_oe`=0, `mem_latch_clk`=0, `mem_oe_n`=1, `mem_we_n`=1, `out_latch_clk`=0
  - both `done`=0, both `rdata`=0, `busy`=0, `owner`=0
  - state IDLE, `last_owner`=1
- IDLE: requests are sampled only here. The winner's addr/we/wdata are captured into internal registers, and `owner` is set. Operand changes after capture are ignored.
- Arbitration: with a single requester, that requester wins. For ties, see Configuration.
- Read path: IDLE → ADDR → LATCH → RD_OE → RD_SAMPLE → RD_DONE → IDLE.
  - ADDR: `bus_out`=addr, `bus_oe`=1.
  - LATCH: `mem_latch_clk`=1; address stays driven.
  - RD_OE: `bus_oe`=0, `mem_oe_n`=0.
  - RD_SAMPLE: `mem_oe_n`=0; the owner's `rdata` captures `bus_in` at the exiting edge.
  - RD_DONE: `mem_oe_n`=1, `mem_latch_clk`=0, owner's `done`=1.
- Write path: IDLE → ADDR → LATCH → WR_DATA → WR_STROBE → WR_END → IDLE.
  - WR_DATA: `bus_out`=wdata, `bus_oe`=1, `mem_latch_clk` stays 1.
  - WR_STROBE: `mem_we_n`=0, or `out_latch_clk`=1 if addr = 0xFF.
  - WR_END: strobes deasserted, data still driven, owner's `done`=1.
- Address 0xFF:
  - Writes never assert `mem_we_n`.
  - Reads of 0xFF access SRAM normally.
- `last_owner` updates to `owner` in each done state.
- Reset mid-access: all outputs return to reset values immediately (async). No `done` is issued, and the aborted access is not retried.

## Timing
- Request sampled at edge N (state IDLE).
  - ADDR during cycle N+1.
  - `done` high during cycle N+5.
  - Back in IDLE at cycle N+6.
- Throughput: one access per 6 cycles.
- `done` is exactly one cycle wide.
- Requester rule: deassert `req` (or change operands for a new access) on the edge ending the `done` cycle. `req` still high in the following IDLE is a new request.
- `mem_we_n` and `out_latch_clk` low/high pulses are exactly one cycle. `bus_out` is stable one cycle before, during, and one cycle after the pulse.
- `bus_oe` and `mem_oe_n` are never both active in the same cycle.

## Configuration
- `SUBNEG_ARB_RR_EN` defined: round-robin. On a tie, the port ≠ `last_owner` wins, so the CPU wins the first tie after reset and contending ports alternate.
- Not defined: fixed priority, host always wins ties. `last_owner` is still maintained but unused.

## Test plan
- CPU read 0x10, SRAM model returns 0x5A:
  - Strobe order ADDR, latch rise, OE low.
  - `cpu_rdata`=0x5A with `cpu_done` at N+5; `host_done` stays 0.
- Host write 0x33 to 0x20:
  - `bus_out`=0x20 latched, then `bus_out`=0x33.
  - `mem_we_n` low exactly at N+4; SRAM[0x20]=0x33; `host_done` at N+5.
- CPU write 0x77 to 0xFF:
  - Single `out_latch_clk` pulse with `bus_out`=0x77.
  - `mem_we_n` stays 1; SRAM unchanged.
- Both ports requesting continuously:
  - With `SUBNEG_ARB_RR_EN`: grants CPU, host, CPU, host…, each `done` 6 cycles apart.
  - Without: host only, CPU starves until host drops `req`.
- `rst_n` asserted during WR_STROBE:
  - `mem_we_n`=1 and `bus_oe`=0 within the same cycle (async); no `done` pulse.
  - After release, IDLE and a fresh CPU read completes normally.
- Back-to-back CPU reads with `req` held high through `done`: a second access starts at N+6, and `cpu_rdata` updates only at the second `done`.
